// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side bit controller for the UART RX path.
// Synchronises the serial line and qualifies the start bit. Mid-bit sampling
// is timed from an oversample tick. Each data/parity sample goes to a SIPO
// register with a one-cycle shift strobe. Parity and the stop bit are checked
// on the fly.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   - each sample point is a 2-of-3 majority of rx_s at counts S-2, S-1, S
//   undefined - single sample of rx_s at count S
//
// Ports:
//   CLK         system clock
//   RST         asynchronous reset, active-high
//   RX_in       raw serial line, idle high, asynchronous to CLK
//   tick        oversample enable, one-CLK pulse, OVERSAMPLE per bit
//   sample_bit  last sampled data/parity bit, held between strobes
//   shift       one-CLK strobe, sample_bit valid
//   busy        high whenever the controller is not idle
//   done        one-CLK pulse at the end of every completed frame
//   parity_err  parity result of the last completed frame
//   frame_err   stop bit of the last completed frame was sampled low
module uart_rx_ctrl #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic RX_in,
    input  logic tick,
    output logic sample_bit,
    output logic shift,
    output logic busy,
    output logic done,
    output logic parity_err,
    output logic frame_err
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bitcnt;
    logic             par;
    logic             perr;
    logic [1:0]       sync;
    logic             rx_s;
    logic             rx_v;

    // Two-flop synchroniser; resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], RX_in};
        end
    end

    assign rx_s = sync[1];

`ifdef UART_RX_MAJORITY_EN
    // The two previous tick samples; consecutive ticks inside a bit are counts S-2 and S-1
    logic [1:0] hist;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist <= 2'b11;
        end else if (tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign rx_v = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign rx_v = rx_s;
`endif

    // Frame sequencer with registered strobes and status
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            par        <= 1'b0;
            perr       <= 1'b0;
            sample_bit <= 1'b0;
            shift      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            shift <= 1'b0;
            done  <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= S_START;
                            busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (cnt == CNT_HALF) begin
                            cnt <= '0;
                            if (rx_v) begin
                                // line back high at mid start bit: treat as noise
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state  <= S_DATA;
                                bitcnt <= '0;
                                par    <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt        <= '0;
                            sample_bit <= rx_v;
                            shift      <= 1'b1;
                            par        <= par ^ rx_v;
                            bitcnt     <= bitcnt + BIT_W'(1);
                            if (bitcnt == BIT_LAST) begin
                                state <= S_PARITY;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (cnt == CNT_LAST) begin
                            cnt        <= '0;
                            sample_bit <= rx_v;
                            shift      <= 1'b1;
                            perr       <= rx_v ^ par ^ PARITY_ODD;
                            state      <= S_STOP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt        <= '0;
                            done       <= 1'b1;
                            parity_err <= perr;
                            frame_err  <= ~rx_v;
                            // a low stop bit parks in BREAK so a held-low line cannot retrigger
                            state      <= rx_v ? S_IDLE : S_BREAK;
                            busy       <= ~rx_v;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_BREAK: begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: randomized frames driven on the serial line,
// expected SIPO bits and frame status queued per frame and checked by an
// independent monitor whenever the DUT strobes shift or done.
module tb_uart_rx_ctrl;

    localparam int unsigned OS   = 16;
    localparam int unsigned DB   = 8;
    localparam bit          PODD = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    logic RX_in;
    logic tick;
    logic sample_bit;
    logic shift;
    logic busy;
    logic done;
    logic parity_err;
    logic frame_err;

    int vectors     = 0;
    int miscompares = 0;

    logic       exp_shift_q[$];
    logic [1:0] exp_done_q[$];   // {parity_err, frame_err}

    uart_rx_ctrl #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY_ODD (PODD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_in      (RX_in),
        .tick       (tick),
        .sample_bit (sample_bit),
        .shift      (shift),
        .busy       (busy),
        .done       (done),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " sample_bit"}, sample_bit, 1'b0);
        check({tag, " shift"},      shift,      1'b0);
        check({tag, " busy"},       busy,       1'b0);
        check({tag, " done"},       done,       1'b0);
        check({tag, " parity_err"}, parity_err, 1'b0);
        check({tag, " frame_err"},  frame_err,  1'b0);
    endtask

    // Drive one line level for n bit-slots of one CLK each, changing at negedge
    task automatic slots(input logic v, input int n);
        repeat (n) begin
            RX_in = v;
            @(negedge CLK);
        end
    endtask

    // One frame: start, DB data bits LSB first, parity, stop.
    // glitch inverts the line for one CLK at the sampling point of each data/parity bit.
    task automatic send_frame(input logic [DB-1:0] data, input bit par_flip,
                              input bit stop_bad, input bit glitch);
        logic [DB:0] tx;
        int          ones;
        logic        e;
        logic        perr;
        tx[DB-1:0] = data;
        tx[DB]     = (^data) ^ PODD ^ par_flip;
        ones = 0;
        for (int i = 0; i <= int'(DB); i++) begin
            // without majority voting the receiver reads the glitched level
            e = tx[i] ^ (glitch & !MAJ);
            exp_shift_q.push_back(e);
            ones += int'(e);
        end
        perr = ((ones % 2) != int'(PODD));
        exp_done_q.push_back({perr, stop_bad});

        slots(1'b0, OS);
        for (int i = 0; i <= int'(DB); i++) begin
            if (glitch) begin
                slots(tx[i], OS / 2);
                slots(~tx[i], 1);
                slots(tx[i], OS / 2 - 1);
            end else begin
                slots(tx[i], OS);
            end
        end
        if (stop_bad) begin
            slots(1'b0, OS + 40);
            check("break holds busy", busy, 1'b1);
            slots(1'b1, 4);
            check("break exit busy", busy, 1'b0);
        end else begin
            slots(1'b1, OS);
        end
        slots(1'b1, $urandom_range(2, 20));
    endtask

    // Monitor: pop and compare whenever the DUT strobes
    initial begin
        logic [1:0] d;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b1) begin
                if (shift === 1'b1) begin
                    if (exp_shift_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected shift: got 1 expected 0 at %0t", $time);
                    end else begin
                        check("shift sample_bit", sample_bit, exp_shift_q.pop_front());
                    end
                end
                if (done === 1'b1) begin
                    if (exp_done_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected done: got 1 expected 0 at %0t", $time);
                    end else begin
                        d = exp_done_q.pop_front();
                        check("done parity_err", parity_err, d[1]);
                        check("done frame_err",  frame_err,  d[0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DB-1:0] rnd;
        int            k;
        logic [DB-1:0] d55;

        RST   = 1'b1;
        RX_in = 1'b1;
        tick  = 1'b1;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        slots(1'b1, 5);

        // good frame, parity error, then a good frame clearing it
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);

        // low stop bit followed by a held-low line
        rnd = DB'($urandom);
        send_frame(rnd, 1'b0, 1'b1, 1'b0);

        // short low pulse in idle: start entered, then rejected
        slots(1'b0, 5);
        check("false start busy", busy, 1'b1);
        slots(1'b1, 40);
        check("false start return", busy, 1'b0);

        // line toggling with tick held low is ignored
        tick = 1'b0;
        slots(1'b0, 10);
        check("no tick busy", busy, 1'b0);
        slots(1'b1, 5);
        tick = 1'b1;
        slots(1'b1, 5);
        check("no tick resume busy", busy, 1'b0);

        // async reset during the 4th data bit
        d55 = 8'h55;
        for (int i = 0; i < 3; i++) exp_shift_q.push_back(d55[i]);
        slots(1'b0, OS);
        for (int i = 0; i < 3; i++) slots(d55[i], OS);
        slots(d55[3], 4);
        RST   = 1'b1;
        RX_in = 1'b1;
        #1;
        check_all_zero("mid-frame reset");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("reset shift queue drained", exp_shift_q.size() == 0, 1'b1);
        check("reset no pending done", exp_done_q.size() == 0, 1'b1);
        slots(1'b1, 5);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);

        // glitch at every bit centre
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);

        // randomized frames
        repeat (24) begin
            rnd = DB'($urandom);
            k   = $urandom_range(0, 3);
            send_frame(rnd, k == 1, k == 2, k == 3);
        end

        slots(1'b1, 40);
        check("end shift queue empty", exp_shift_q.size() == 0, 1'b1);
        check("end done queue empty", exp_done_q.size() == 0, 1'b1);
        check("end idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side bit controller for the UART RX path. It synchronises the serial line, detects and qualifies the start bit, and times mid-bit sampling from an oversample tick. It drives the sampled bit and a one-cycle shift strobe into the downstream serial-to-parallel register. It also checks parity and the stop bit on the fly and reports frame completion and errors.

Parameters:
OVERSAMPLE, 16, ticks per bit period; even, >= 8
DATA_BITS, 8, data bits per frame, LSB first
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous reset, active-high
RX_in  input  1  raw serial line, idle high, asynchronous to CLK
tick  input  1  oversample enable, one-CLK pulse, OVERSAMPLE per bit
sample_bit  output  1  last sampled data/parity bit, held between strobes
shift  output  1  one-CLK strobe, sample_bit valid, to SIPO shift input
busy  output  1  high in any state other than IDLE
done  output  1  one-CLK pulse at end of every completed frame
parity_err  output  1  parity result of last completed frame
frame_err  output  1  stop bit of last completed frame sampled low

Behaviour:
- Reset and synchronisation
  - Reset: all outputs 0, state IDLE, counters 0.
  - RX_in passes through 2-flop synchroniser; sync flops reset to 1 to avoid a false start.
  - rx_s denotes the synchroniser output.
- Tick gating
  - All counting and sampling occur only on CLK edges with tick=1.
  - tick=0 freezes the FSM.
- Counters and parity
  - cnt: log2(OVERSAMPLE) bits, wraps to 0 after OVERSAMPLE-1.
  - bitcnt: counts data bits.
  - par: running XOR of sampled data bits.
- States
  - IDLE: on tick with rx_s=0 -> START, cnt=0.
  - START: at cnt=OVERSAMPLE/2-1, sample.
    - Sample 1: false start -> IDLE, no strobe.
    - Sample 0: -> DATA, cnt=0, bitcnt=0, par=0.
  - DATA: at cnt=OVERSAMPLE-1, sample into sample_bit, pulse shift, par ^= sample, bitcnt++.
    - After DATA_BITS samples -> PARITY.
  - PARITY: at cnt=OVERSAMPLE-1, sample into sample_bit and pulse shift.
    - Store perr = sample ^ par ^ PARITY_ODD.
    - -> STOP.
  - STOP: at cnt=OVERSAMPLE-1, sample.
    - Pulse done; parity_err <= perr; frame_err <= ~sample.
    - Sample 1 -> IDLE; sample 0 -> BREAK.
  - BREAK: stay until a tick with rx_s=1 -> IDLE. Prevents a low line from retriggering START.
- Timing
  - shift and done are registered: asserted in the CLK cycle after the sampling tick, exactly one cycle wide.
  - shift fires DATA_BITS+1 times per frame; never on start or stop.
  - parity_err and frame_err update only with done and hold until the next done.
  - The SIPO receives DATA_BITS+1 shifts per good frame.
- Boundary conditions
  - Async RST mid-frame: immediate return to IDLE with all outputs 0; no done, no partial strobe.
  - rx_s toggling in IDLE without a tick: ignored.
  - tick high every CLK: legal; bit period = OVERSAMPLE CLKs.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point uses a 2-of-3 majority of rx_s at the sample count S-2, S-1 and S, where S is the single-sample count.
  - The decision is taken at S; strobe timing is unchanged.
  - The START false-start check also uses the majority value.
- Undefined: single sample of rx_s at count S.

Test Plan:
1. OVERSAMPLE=16, tick every CLK, frame 0 / 0xA5 LSB-first / parity 0 / stop 1 -> 9 shift pulses with sample_bit 1,0,1,0,0,1,0,1,0; one done; parity_err=0, frame_err=0.
2. Same frame with parity bit 1 -> done, parity_err=1, frame_err=0; next good 0x3C frame clears parity_err to 0.
3. Stop bit driven 0, line held low 40 CLKs then high -> done, frame_err=1; state BREAK until high; no new START while low; busy falls after line high.
4. RX_in low pulse of 5 CLKs in idle -> START entered, sample at count 7 reads 1, return to IDLE; no shift, no done.
5. Assert RST at 4th data bit -> all outputs 0 immediately; next full 0x55 frame received correctly.
6. With UART_RX_MAJORITY_EN, 1-CLK glitch inverting each bit centre of 0xA5 frame -> identical result to scenario 1; without macro, corrupted bits observed.
